// File: rtl/ahb_lite_master_if.sv
// AHB-Lite master bundle: user command/response side plus AHB-Lite bus side.
// master modport = the bridge's view; slave modport = user + bus slave view.
interface ahb_lite_master_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 2
) ();
  localparam int DW = DATA_WIDTH * 8;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DW-1:0]         cmd_wdata;
  logic                  cmd_size;

  logic                  rsp_valid;
  logic [DW-1:0]         rsp_rdata;
  logic                  rsp_error;
  logic                  busy;

  logic                  hsel;
  logic [1:0]            htrans;
  logic [ADDR_WIDTH-1:0] haddr;
  logic [2:0]            hsize;
  logic                  hwrite;
  logic [DW-1:0]         hwdata;
  logic [DW-1:0]         hrdata;
  logic                  hresp;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_size,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_error, busy,
    output hsel, htrans, haddr, hsize, hwrite, hwdata,
    input  hrdata, hresp
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_size,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_error, busy,
    input  hsel, htrans, haddr, hsize, hwrite, hwdata,
    output hrdata, hresp
  );
endinterface

// File: rtl/ahb_lite_master.sv
// Pipelined AHB-Lite master: address stage, data stage, response stage.
// Ports: clk, rst (async, active-high), bus (ahb_lite_master_if.master).
module ahb_lite_master #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 2
) (
  input logic               clk,
  input logic               rst,
  ahb_lite_master_if.master bus
);
  localparam int DW = DATA_WIDTH * 8;

  logic          w_accept;
  logic          w_mis;
  logic          w_xfer;
  logic [DW-1:0] w_wdata;
  logic          w_err;
  logic [7:0]    w_byte;
  logic [DW-1:0] w_rdata;

  logic          r_a_valid;
  logic          r_a_write;
  logic          r_a_size;
  logic          r_a_a0;
  logic          r_a_mis;
  logic [DW-1:0] r_a_wdata;

  logic          r_d_valid;
  logic          r_d_write;
  logic          r_d_size;
  logic          r_d_a0;
  logic          r_d_mis;

  logic                  r_hsel;
  logic [1:0]            r_htrans;
  logic [ADDR_WIDTH-1:0] r_haddr;
  logic [2:0]            r_hsize;
  logic                  r_hwrite;
  logic [DW-1:0]         r_hwdata;

  logic          r_rsp_valid;
  logic [DW-1:0] r_rsp_rdata;
  logic          r_rsp_error;
  logic          r_busy;

  assign bus.cmd_ready = ~rst;
  assign w_accept = bus.cmd_valid & ~rst;
  assign w_mis    = bus.cmd_size & bus.cmd_addr[0];
  assign w_xfer   = w_accept & ~w_mis;
  // byte writes drive the same byte on every lane
  assign w_wdata  = bus.cmd_size ? bus.cmd_wdata
                  : {DATA_WIDTH{bus.cmd_wdata[7:0]}};

  // misaligned commands never reached the bus, so hresp is meaningless
  assign w_err   = r_d_mis | bus.hresp;
  assign w_byte  = r_d_a0 ? bus.hrdata[8 +: 8] : bus.hrdata[7:0];
  assign w_rdata = r_d_size ? bus.hrdata
                 : {{(DW-8){1'b0}}, w_byte};

  assign bus.hsel      = r_hsel;
  assign bus.htrans    = r_htrans;
  assign bus.haddr     = r_haddr;
  assign bus.hsize     = r_hsize;
  assign bus.hwrite    = r_hwrite;
  assign bus.hwdata    = r_hwdata;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_error = r_rsp_error;
  assign bus.busy      = r_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_valid <= 1'b0;
      r_a_write <= 1'b0;
      r_a_size  <= 1'b0;
      r_a_a0    <= 1'b0;
      r_a_mis   <= 1'b0;
      r_a_wdata <= '0;
      r_hsel    <= 1'b0;
      r_htrans  <= 2'b00;
      r_haddr   <= '0;
      r_hsize   <= 3'b000;
      r_hwrite  <= 1'b0;
    end else begin
      r_a_valid <= w_accept;
      r_a_write <= w_accept & bus.cmd_write;
      r_a_size  <= w_accept & bus.cmd_size;
      r_a_a0    <= w_accept & bus.cmd_addr[0];
      r_a_mis   <= w_accept & w_mis;
      r_a_wdata <= w_accept ? w_wdata : '0;
      r_hsel    <= w_xfer;
      r_htrans  <= w_xfer ? 2'b10 : 2'b00;
      r_haddr   <= w_xfer ? bus.cmd_addr : '0;
      r_hsize   <= w_xfer ? {2'b00, bus.cmd_size} : 3'b000;
      r_hwrite  <= w_xfer & bus.cmd_write;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d_valid <= 1'b0;
      r_d_write <= 1'b0;
      r_d_size  <= 1'b0;
      r_d_a0    <= 1'b0;
      r_d_mis   <= 1'b0;
      r_hwdata  <= '0;
    end else begin
      r_d_valid <= r_a_valid;
      r_d_write <= r_a_write;
      r_d_size  <= r_a_size;
      r_d_a0    <= r_a_a0;
      r_d_mis   <= r_a_mis;
      r_hwdata  <= (r_a_write & ~r_a_mis) ? r_a_wdata : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_error <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rsp_valid <= r_d_valid;
      r_rsp_error <= r_d_valid & w_err;
      r_rsp_rdata <= (r_d_valid & ~w_err & ~r_d_write) ? w_rdata : '0;
      // next-state OR of the three stage-valid flags
      r_busy      <= w_accept | r_a_valid | r_d_valid;
    end
  end
endmodule

// File: tb/tb_ahb_lite_master.sv
// Randomized bench for ahb_lite_master with a per-cycle transaction model.
// Directed rows first, then random traffic with occasional resets.
module tb_ahb_lite_master;
  localparam int AW   = 4;
  localparam int DB   = 2;
  localparam int NRND = 500;
  localparam int N    = 600;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ahb_lite_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DB)) bus ();

  ahb_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct {
    bit v; bit w; bit sz; bit he; bit r;
    int addr; int wd; int hr;
  } stim_t;

  stim_t dq[$];
  stim_t hist[N];
  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h",
               tag, cyc, got, exp);
    end
  endtask

  task automatic row(input bit v, input bit w, input bit sz,
                     input int addr, input int wd, input int hr,
                     input bit he, input bit r);
    stim_t s;
    s.v = v; s.w = w; s.sz = sz; s.addr = addr; s.wd = wd;
    s.hr = hr; s.he = he; s.r = r;
    dq.push_back(s);
  endtask

  function automatic bit on_bus(input stim_t x);
    return x.v && !(x.sz && (x.addr % 2 == 1));
  endfunction

  task automatic check_cycle(input int c);
    stim_t a, d, q;
    bit err;
    int rd;
    if (rst) begin
      check("rst_ready",  bus.cmd_ready, 0);
      check("rst_rspv",   bus.rsp_valid, 0);
      check("rst_rdata",  bus.rsp_rdata, 0);
      check("rst_err",    bus.rsp_error, 0);
      check("rst_busy",   bus.busy, 0);
      check("rst_hsel",   bus.hsel, 0);
      check("rst_htrans", bus.htrans, 0);
      check("rst_haddr",  bus.haddr, 0);
      check("rst_hwrite", bus.hwrite, 0);
      check("rst_hsize",  bus.hsize, 0);
      check("rst_hwdata", bus.hwdata, 0);
    end else begin
      a = hist[c]; d = hist[c-1]; q = hist[c-2];
      check("ready", bus.cmd_ready, 1);
      check("hsel", bus.hsel, on_bus(a));
      check("htrans", bus.htrans, on_bus(a) ? 2 : 0);
      check("haddr", bus.haddr, on_bus(a) ? a.addr : 0);
      check("hwrite", bus.hwrite, on_bus(a) ? a.w : 0);
      check("hsize", bus.hsize, on_bus(a) ? a.sz : 0);
      if (on_bus(d) && d.w)
        check("hwdata", bus.hwdata,
              d.sz ? d.wd : (d.wd % 256) * 257);
      check("busy", bus.busy, a.v || d.v || q.v);
      check("rspv", bus.rsp_valid, q.v);
      err = q.v && (!on_bus(q) || q.he);
      rd = 0;
      if (q.v && !err && !q.w)
        rd = q.sz ? q.hr : (q.hr >> (8 * (q.addr % 2))) % 256;
      check("rsperr", bus.rsp_error, err);
      check("rdata", bus.rsp_rdata, rd);
    end
  endtask

  initial begin
    stim_t s;
    int total;
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = 0;
    bus.cmd_wdata = 0; bus.cmd_size = 0;
    bus.hrdata = 0; bus.hresp = 0;

    repeat (3) row(0, 0, 0, 0, 0, 0, 0, 1);
    row(1, 1, 1, 4, 16'h03E8, 0, 0, 0);
    row(0, 0, 0, 0, 0, 0, 0, 0);
    row(1, 0, 0, 3, 0, 16'hAB12, 0, 0);
    row(0, 0, 0, 0, 0, 0, 0, 0);
    row(1, 1, 1, 5, 16'h1111, 0, 0, 0);
    row(0, 0, 0, 0, 0, 0, 0, 0);
    row(1, 1, 1, 0, 16'h2222, 0, 1, 0);
    row(1, 0, 1, 6, 0, 16'h5A5A, 0, 0);
    row(0, 0, 0, 0, 0, 0, 0, 0);
    row(1, 1, 1, 6, 16'h8000, 0, 0, 0);
    row(1, 0, 1, 6, 0, 16'h8000, 0, 0);
    row(1, 0, 1, 4, 0, 16'h1234, 0, 0);
    repeat (3) row(0, 0, 0, 0, 0, 0, 0, 0);
    row(1, 0, 1, 2, 0, 16'h7777, 0, 0);
    row(1, 0, 1, 2, 0, 16'h7777, 0, 1);
    row(1, 0, 1, 2, 0, 16'h7777, 0, 1);
    repeat (3) row(0, 0, 0, 0, 0, 0, 0, 0);

    total = dq.size() + NRND;
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      cyc = c;
      check_cycle(c);
      if (dq.size() != 0) begin
        s = dq.pop_front();
      end else begin
        s.v = ($urandom_range(0, 3) != 0);
        s.w = $urandom_range(0, 1);
        s.sz = $urandom_range(0, 1);
        s.addr = $urandom_range(0, 15);
        s.wd = $urandom_range(0, 65535);
        s.hr = $urandom_range(0, 65535);
        s.he = ($urandom_range(0, 7) == 0);
        s.r = ($urandom_range(0, 79) == 0);
      end
      if (s.r) begin
        hist[c].v = 0;
        if (c > 0) hist[c-1].v = 0;
      end
      rst = s.r;
      hist[c+1] = s;
      hist[c+1].v = s.v && !s.r;
      bus.cmd_valid = s.v;
      bus.cmd_write = s.w;
      bus.cmd_size  = s.sz;
      bus.cmd_addr  = s.addr[AW-1:0];
      bus.cmd_wdata = s.wd[15:0];
      if (c > 0) begin
        bus.hrdata = hist[c-1].hr[15:0];
        bus.hresp  = hist[c-1].he;
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/ahb_lite_master.md
AHB_LITE_MASTER -- requirements
Module: ahb_lite_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, haddr/cmd_addr width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 2, data bus width in bytes (data bits = DATA_WIDTH*8 = 16).
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  system clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 cmd_valid  in  1  user request present.
REQ-007 cmd_ready  out  1  request accepted when cmd_valid & cmd_ready at rising edge.
REQ-008 cmd_write  in  1  1 = write, 0 = read.
REQ-009 cmd_addr  in  ADDR_WIDTH  byte address.
REQ-010 cmd_wdata  in  16  write data; byte writes use bits [7:0].
REQ-011 cmd_size  in  1  0 = byte, 1 = halfword.
REQ-012 rsp_valid  out  1  one-cycle response strobe, one per accepted command.
REQ-013 rsp_rdata  out  16  read data; 0 for writes and errors.
REQ-014 rsp_error  out  1  transfer failed (slave hresp or local misalignment).
REQ-015 busy  out  1  any command in address phase, data phase or response stage.
REQ-016 hsel, htrans[1:0], haddr[ADDR_WIDTH-1:0], hsize[2:0], hwrite, hwdata[15:0]  out  AHB-Lite address/data-phase signals.
REQ-017 hrdata[15:0], hresp  in  slave read data and error response; no hready exists.

Function
REQ-018 All outputs SHALL be registered except cmd_ready.
REQ-019 cmd_ready SHALL be 1 whenever rst is low; throughput is one command per cycle.
REQ-020 A command accepted at edge E0 SHALL drive its address phase during E0..E1: hsel=1, htrans=2'b10 (NONSEQ), haddr=cmd_addr, hwrite=cmd_write, hsize={2'b00,cmd_size}.
REQ-021 Its data phase SHALL occupy E1..E2; hwdata SHALL hold write data during that cycle; hrdata/hresp SHALL be sampled at E2.
REQ-022 rsp_valid SHALL be high for exactly the cycle E2..E3, with rsp_rdata/rsp_error for that command.
REQ-023 Cycles with no address phase SHALL drive hsel=0, htrans=2'b00, haddr=0, hwrite=0, hsize=0.
REQ-024 Back-to-back commands SHALL overlap: command N+1 address phase coincides with command N data phase; responses stay in order.
REQ-025 Byte write SHALL replicate cmd_wdata[7:0] on both hwdata lanes.
REQ-026 Byte read SHALL return hrdata[15:8] if addr[0]=1, else hrdata[7:0], zero-extended.
REQ-027 Halfword read SHALL return hrdata unchanged.
REQ-028 Halfword command with cmd_addr[0]=1 SHALL issue no bus transfer (IDLE in its address slot), and SHALL still produce rsp_valid at E2 with rsp_error=1, rsp_rdata=0.
REQ-029 hresp=1 sampled at E2 SHALL give rsp_error=1, rsp_rdata=0; the following command already in address phase SHALL complete normally.
REQ-030 Pipeline stages SHALL be: address stage (valid, write, size, addr[0], wdata, misaligned), data stage (same fields), response stage (rsp registers).
REQ-031 busy SHALL equal the OR of the three stage-valid flags.

Reset
REQ-032 rst high SHALL immediately clear all stage-valid flags, rsp_valid=0, rsp_rdata=0, rsp_error=0, busy=0, and drive idle bus values per REQ-023, hwdata=0.
REQ-033 Commands in flight at reset assertion SHALL be discarded with no response; cmd_ready SHALL be 0 while rst is high.

Verification
REQ-034 Halfword write 0x03E8 to addr 4 -> one cycle hsel=1, htrans=10, haddr=4, hwrite=1, hsize=001; next cycle hwdata=0x03E8; rsp_valid=1, rsp_error=0 two cycles after acceptance.
REQ-035 Byte read addr 3, slave hrdata=0xAB12 -> hsize=000; rsp_rdata=0x00AB, rsp_error=0.
REQ-036 Halfword write addr 5 -> htrans stays 00 all cycles; rsp_valid with rsp_error=1 at normal latency.
REQ-037 Write addr 0 with hresp=1 in data phase, read addr 6 queued behind it -> first rsp_error=1, second rsp_error=0 with correct data in the next cycle.
REQ-038 Three consecutive accepted commands (write 6=0x8000, read 6, read 4) -> three consecutive NONSEQ cycles, three consecutive rsp_valid cycles, in order, busy high throughout.
REQ-039 rst asserted one cycle after accepting a read -> no rsp_valid, all outputs at reset values during rst, busy=0.
